// File: rtl/reg_scoreboard_pkg.sv
// reg_scoreboard_pkg
// Shared sizing constants for the decode-stage register scoreboard, plus the
// writeback bypass selection used on each of the three operand paths.
//   NUM_REGS      architectural register count (register 0 is hardwired zero)
//   REG_W         register number width
//   DATA_W        register data width
//   CNT_W_DEFAULT default width of each outstanding-write counter
package reg_scoreboard_pkg;

  localparam int NUM_REGS      = 32;
  localparam int REG_W         = 5;
  localparam int DATA_W        = 32;
  localparam int CNT_W_DEFAULT = 2;

  // The register file only commits at the clock edge, so a read of the
  // register being written this cycle must take the writeback data instead.
  // Register 0 is never bypassed; its read data is already zero.
  function automatic logic [DATA_W-1:0] bypass(
    input logic              wr_en,
    input logic [REG_W-1:0]  wr_reg,
    input logic [REG_W-1:0]  src_reg,
    input logic [DATA_W-1:0] wr_data,
    input logic [DATA_W-1:0] rf_data
  );
    if (wr_en && (wr_reg == src_reg) && (src_reg != '0))
      return wr_data;
    return rf_data;
  endfunction

endpackage

// File: rtl/reg_scoreboard_counter.sv
// sb_counter
// One per-register outstanding-write counter.
//   CLK, RESET  clock, asynchronous active-low reset
//   inc         an issue targeting this register was accepted
//   dec         a writeback to this register retired
//   clr         flush: drop every in-flight write
//   nonzero     at least one write outstanding
//   is_one      exactly one write outstanding
//   is_max      counter saturated
module sb_counter #(
  parameter int CNT_W = 2
) (
  input  logic CLK,
  input  logic RESET,
  input  logic inc,
  input  logic dec,
  input  logic clr,
  output logic nonzero,
  output logic is_one,
  output logic is_max
);

  logic [CNT_W-1:0] count;

  assign nonzero = (count != '0);
  assign is_one  = (count == CNT_W'(1));
  assign is_max  = &count;

  // Simultaneous inc and dec cancel. The saturation guards only matter if a
  // caller ignores nonzero/is_max; the scoreboard never does.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !dec) begin
      if (!is_max)
        count <= count + CNT_W'(1);
    end else if (dec && !inc) begin
      if (nonzero)
        count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/reg_scoreboard.sv
// reg_scoreboard
// Decode-stage register scoreboard with writeback bypass. Tracks in-flight
// writes per architectural register, stalls issue on RAW hazards or counter
// saturation, and forwards same-cycle writeback data onto the operand paths.
//   CLK, RESET                 clock, asynchronous active-low reset
//   Issue_Valid/Writes/Dest    instruction presented by decode
//   UseA/B/C, RegA1/B1/C1      source operands read and their registers
//   DataA1/B1/C1               raw register file read data
//   Write1/WriteReg1/WriteData1 writeback port (same as register file write)
//   Flush                      squash all in-flight instructions
//   Stall                      issue blocked this cycle
//   FwdA/B/C                   operand data after bypass
//   Pending                    bit r set while register r has writes in flight
//   Underflow                  sticky: writeback with no write outstanding
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              Issue_Valid,
  input  logic              Issue_Writes,
  input  logic [REG_W-1:0]  Issue_Dest,
  input  logic              UseA,
  input  logic              UseB,
  input  logic              UseC,
  input  logic [REG_W-1:0]  RegA1,
  input  logic [REG_W-1:0]  RegB1,
  input  logic [REG_W-1:0]  RegC1,
  input  logic [DATA_W-1:0] DataA1,
  input  logic [DATA_W-1:0] DataB1,
  input  logic [DATA_W-1:0] DataC1,
  input  logic              Write1,
  input  logic [REG_W-1:0]  WriteReg1,
  input  logic [DATA_W-1:0] WriteData1,
  input  logic              Flush,
  output logic              Stall,
  output logic [DATA_W-1:0] FwdA,
  output logic [DATA_W-1:0] FwdB,
  output logic [DATA_W-1:0] FwdC,
  output logic [NUM_REGS-1:0] Pending,
  output logic              Underflow
);

  logic [NUM_REGS-1:0] nonzero;
  logic [NUM_REGS-1:0] is_one;
  logic [NUM_REGS-1:0] is_max;
  logic [NUM_REGS-1:0] inc;
  logic [NUM_REGS-1:0] dec;

  logic wr_valid;
  logic haz_a;
  logic haz_b;
  logic haz_c;
  logic dest_full;
  logic accept;

  // Register 0 is never tracked; tying its flags low makes every hazard and
  // retire term false for it without extra comparisons.
  assign nonzero[0] = 1'b0;
  assign is_one[0]  = 1'b0;
  assign is_max[0]  = 1'b0;
  assign inc[0]     = 1'b0;
  assign dec[0]     = 1'b0;

  assign wr_valid = Write1 && (WriteReg1 != '0);

  genvar r;
  generate
    for (r = 1; r < NUM_REGS; r++) begin : g_cnt
      assign dec[r] = wr_valid && (WriteReg1 == REG_W'(r)) && nonzero[r];
      assign inc[r] = accept && (Issue_Dest == REG_W'(r));

      sb_counter #(.CNT_W(CNT_W)) u_cnt (
        .CLK     (CLK),
        .RESET   (RESET),
        .inc     (inc[r]),
        .dec     (dec[r]),
        .clr     (Flush),
        .nonzero (nonzero[r]),
        .is_one  (is_one[r]),
        .is_max  (is_max[r])
      );
    end
  endgenerate

  // A source waiting only on the write retiring this cycle is satisfied by
  // the bypass. A full destination counter frees a slot if it retires now.
  always_comb begin
    haz_a     = UseA && nonzero[RegA1] && !(is_one[RegA1] && dec[RegA1]);
    haz_b     = UseB && nonzero[RegB1] && !(is_one[RegB1] && dec[RegB1]);
    haz_c     = UseC && nonzero[RegC1] && !(is_one[RegC1] && dec[RegC1]);
    dest_full = Issue_Writes && is_max[Issue_Dest] && !dec[Issue_Dest];
    Stall     = Issue_Valid && (haz_a || haz_b || haz_c || dest_full);
    accept    = Issue_Valid && !Stall && Issue_Writes && (Issue_Dest != '0);
  end

  assign FwdA    = bypass(Write1, WriteReg1, RegA1, WriteData1, DataA1);
  assign FwdB    = bypass(Write1, WriteReg1, RegB1, WriteData1, DataB1);
  assign FwdC    = bypass(Write1, WriteReg1, RegC1, WriteData1, DataC1);
  assign Pending = nonzero;

  // A writeback for a register with nothing outstanding points at a pipeline
  // bug (or a write surviving a flush); remember it until reset.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)
      Underflow <= 1'b0;
    else if (wr_valid && !nonzero[WriteReg1])
      Underflow <= 1'b1;
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
// tb_reg_scoreboard
// Self-checking bench for reg_scoreboard: a behavioural model of the per-
// register in-flight write counts is checked against the DUT every cycle,
// with directed scenarios pinning literal expectations.
module tb_reg_scoreboard;

  localparam int CNT_W = 2;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        Issue_Valid, Issue_Writes;
  logic [4:0]  Issue_Dest;
  logic        UseA, UseB, UseC;
  logic [4:0]  RegA1, RegB1, RegC1;
  logic [31:0] DataA1, DataB1, DataC1;
  logic        Write1;
  logic [4:0]  WriteReg1;
  logic [31:0] WriteData1;
  logic        Flush;
  logic        Stall;
  logic [31:0] FwdA, FwdB, FwdC;
  logic [31:0] Pending;
  logic        Underflow;

  int total = 0;
  int bad   = 0;

  int cnt[32];
  bit m_uf;

  reg_scoreboard #(.CNT_W(CNT_W)) dut (
    .CLK(CLK), .RESET(RESET),
    .Issue_Valid(Issue_Valid), .Issue_Writes(Issue_Writes), .Issue_Dest(Issue_Dest),
    .UseA(UseA), .UseB(UseB), .UseC(UseC),
    .RegA1(RegA1), .RegB1(RegB1), .RegC1(RegC1),
    .DataA1(DataA1), .DataB1(DataB1), .DataC1(DataC1),
    .Write1(Write1), .WriteReg1(WriteReg1), .WriteData1(WriteData1),
    .Flush(Flush), .Stall(Stall),
    .FwdA(FwdA), .FwdB(FwdB), .FwdC(FwdC),
    .Pending(Pending), .Underflow(Underflow)
  );

  always #5 CLK = ~CLK;

  // Model: a writeback retires one in-flight write if any exist.
  function automatic bit m_retire(int r);
    return Write1 && (int'(WriteReg1) == r) && (r != 0) && (cnt[r] != 0);
  endfunction

  function automatic bit m_haz(bit use_it, int r);
    if (!use_it || r == 0 || cnt[r] == 0) return 1'b0;
    return !(cnt[r] == 1 && m_retire(r));
  endfunction

  function automatic bit m_stall();
    bit full;
    full = Issue_Writes && (Issue_Dest != 0) && (cnt[Issue_Dest] == MAXC) && !m_retire(int'(Issue_Dest));
    return Issue_Valid && (m_haz(UseA, int'(RegA1)) || m_haz(UseB, int'(RegB1)) ||
                           m_haz(UseC, int'(RegC1)) || full);
  endfunction

  function automatic logic [31:0] m_fwd(logic [4:0] rg, logic [31:0] raw);
    if (Write1 && WriteReg1 == rg && rg != 0) return WriteData1;
    return raw;
  endfunction

  function automatic logic [31:0] m_pending();
    logic [31:0] p;
    p = '0;
    for (int i = 1; i < 32; i++) p[i] = (cnt[i] != 0);
    return p;
  endfunction

  task automatic modelClear();
    for (int i = 0; i < 32; i++) cnt[i] = 0;
    m_uf = 1'b0;
  endtask

  task automatic checkLit(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    checkLit("stall", 32'(Stall), 32'(m_stall()));
    checkLit("fwdA", FwdA, m_fwd(RegA1, DataA1));
    checkLit("fwdB", FwdB, m_fwd(RegB1, DataB1));
    checkLit("fwdC", FwdC, m_fwd(RegC1, DataC1));
    checkLit("pending", Pending, m_pending());
    checkLit("underflow", 32'(Underflow), 32'(m_uf));
  endtask

  task automatic clearInputs();
    Issue_Valid = 0; Issue_Writes = 0; Issue_Dest = 0;
    UseA = 0; UseB = 0; UseC = 0; RegA1 = 0; RegB1 = 0; RegC1 = 0;
    DataA1 = 0; DataB1 = 0; DataC1 = 0;
    Write1 = 0; WriteReg1 = 0; WriteData1 = 0; Flush = 0;
  endtask

  // Let combinational outputs settle, then compare against the model.
  task automatic settle();
    #2;
    checkOutput();
  endtask

  // Compute next model state from the inputs present at the edge, then cross it.
  task automatic advance();
    int nxt[32];
    bit st;
    st = m_stall();
    for (int i = 0; i < 32; i++) nxt[i] = cnt[i];
    if (Write1 && WriteReg1 != 0 && cnt[WriteReg1] == 0) m_uf = 1'b1;
    for (int i = 1; i < 32; i++) begin
      if (Issue_Valid && !st && Issue_Writes && int'(Issue_Dest) == i) nxt[i]++;
      if (m_retire(i)) nxt[i]--;
    end
    if (Flush) for (int i = 0; i < 32; i++) nxt[i] = 0;
    @(posedge CLK);
    for (int i = 0; i < 32; i++) cnt[i] = nxt[i];
    #1;
  endtask

  task automatic applyReset();
    RESET = 0;
    modelClear();
    @(posedge CLK);
    #1;
    RESET = 1;
  endtask

  task automatic issueWrite(input logic [4:0] d);
    clearInputs();
    Issue_Valid = 1; Issue_Writes = 1; Issue_Dest = d;
    settle();
    advance();
  endtask

  task automatic applyStimulus();
    int r;
    Issue_Valid  = ($urandom_range(0, 3) != 0);
    Issue_Writes = 1'($urandom_range(0, 1));
    Issue_Dest   = 5'($urandom_range(0, 7));
    UseA = 1'($urandom_range(0, 1)); RegA1 = 5'($urandom_range(0, 7));
    UseB = 1'($urandom_range(0, 1)); RegB1 = 5'($urandom_range(0, 7));
    UseC = 1'($urandom_range(0, 1)); RegC1 = 5'($urandom_range(0, 7));
    DataA1 = $urandom; DataB1 = $urandom; DataC1 = $urandom;
    Write1 = ($urandom_range(0, 2) == 0);
    r = $urandom_range(0, 7);
    if (cnt[r] == 0) r = $urandom_range(0, 7);
    WriteReg1  = 5'(r);
    WriteData1 = $urandom;
    Flush = ($urandom_range(0, 49) == 0);
  endtask

  initial begin
    clearInputs();
    modelClear();
    #3;
    checkLit("reset_pending", Pending, 32'h0);
    checkLit("reset_stall", 32'(Stall), 32'h0);
    checkLit("reset_underflow", 32'(Underflow), 32'h0);
    @(posedge CLK);
    #1;
    RESET = 1;

    // RAW on r5, resolved by a same-cycle writeback bypass
    issueWrite(5'd5);
    clearInputs();
    Issue_Valid = 1; UseA = 1; RegA1 = 5'd5; DataA1 = 32'h1111_1111;
    settle();
    checkLit("raw_stall", 32'(Stall), 32'h1);
    checkLit("raw_pending5", 32'(Pending[5]), 32'h1);
    advance();
    Write1 = 1; WriteReg1 = 5'd5; WriteData1 = 32'hDEADBEEF;
    settle();
    checkLit("bypass_stall", 32'(Stall), 32'h0);
    checkLit("bypass_fwdA", FwdA, 32'hDEADBEEF);
    advance();
    clearInputs();
    settle();
    checkLit("retired_pending5", 32'(Pending[5]), 32'h0);
    advance();

    // Register 0 is never tracked or bypassed
    Issue_Valid = 1; Issue_Writes = 1; Issue_Dest = 0; UseA = 1; RegA1 = 0;
    Write1 = 1; WriteReg1 = 0; WriteData1 = 32'h1234_5678;
    settle();
    checkLit("r0_stall", 32'(Stall), 32'h0);
    checkLit("r0_fwdA", FwdA, 32'h0);
    advance();
    clearInputs();
    settle();
    checkLit("r0_pending", Pending, 32'h0);
    checkLit("r0_underflow", 32'(Underflow), 32'h0);
    advance();

    // Saturation on r7
    issueWrite(5'd7); issueWrite(5'd7); issueWrite(5'd7);
    Issue_Valid = 1; Issue_Writes = 1; Issue_Dest = 5'd7;
    settle();
    checkLit("sat_stall", 32'(Stall), 32'h1);
    Write1 = 1; WriteReg1 = 5'd7;
    settle();
    checkLit("sat_retire_stall", 32'(Stall), 32'h0);
    advance();
    Write1 = 0;
    settle();
    checkLit("sat_still_full", 32'(Stall), 32'h1);
    advance();

    // Two outstanding writes on r9: one writeback is not enough
    applyReset();
    issueWrite(5'd9); issueWrite(5'd9);
    clearInputs();
    Issue_Valid = 1; UseB = 1; RegB1 = 5'd9; Write1 = 1; WriteReg1 = 5'd9;
    settle();
    checkLit("two_pending_stall", 32'(Stall), 32'h1);
    advance();
    settle();
    checkLit("last_pending_stall", 32'(Stall), 32'h0);
    advance();

    // Flush, then a stale writeback raises Underflow
    applyReset();
    issueWrite(5'd3); issueWrite(5'd12);
    clearInputs();
    Flush = 1;
    settle();
    advance();
    clearInputs();
    settle();
    checkLit("flush_pending", Pending, 32'h0);
    Write1 = 1; WriteReg1 = 5'd3;
    advance();
    clearInputs();
    settle();
    checkLit("underflow_set", 32'(Underflow), 32'h1);
    advance();
    settle();
    checkLit("underflow_sticky", 32'(Underflow), 32'h1);
    advance();

    // Asynchronous reset mid-stream
    issueWrite(5'd2); issueWrite(5'd4);
    clearInputs();
    Issue_Valid = 1; UseA = 1; RegA1 = 5'd2; UseB = 1; RegB1 = 5'd4;
    settle();
    checkLit("pre_reset_stall", 32'(Stall), 32'h1);
    RESET = 0;
    modelClear();
    #1;
    checkLit("async_pending", Pending, 32'h0);
    checkLit("async_stall", 32'(Stall), 32'h0);
    checkLit("async_underflow", 32'(Underflow), 32'h0);
    @(posedge CLK);
    #1;
    RESET = 1;

    // Randomized traffic against the model, with one mid-stream reset
    for (int c = 0; c < 600; c++) begin
      applyStimulus();
      settle();
      if (c == 300) begin
        RESET = 0;
        modelClear();
        #1;
        checkOutput();
        @(posedge CLK);
        #1;
        RESET = 1;
      end else begin
        advance();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
